ysyx_22041071_store_buffer: RTL and testbench
=============================================

// Module: ysyx_22041071_store_buffer
// PURPOSE
//  - Posted store buffer between the LSU and the AXI write-channel master (cpu_aw_* / cpu_w_resp side).
//  - Accepts single stores from the LSU, queues them in a DEPTH-entry FIFO and drains them in order.
//  - Drains one single-beat AXI write at a time; the head entry is popped only when the master returns idle.
//  - Flags load/store address hazards and sticky write errors to the core.
// PARAMETERS
//  DEPTH   4   FIFO entries, power of two, >=2
//  ADDR_W  64  address width
//  DATA_W  64  data width (8 byte lanes)
//  ID      0   AXI ID driven on every write
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       synchronous, active-low reset
//  st_valid     in   1       LSU store request
//  st_ready     out  1       buffer can accept a store
//  st_addr      in   ADDR_W  store byte address
//  st_data      in   DATA_W  store data, LSB-justified
//  st_size      in   2       00=1B 01=2B 10=4B 11=8B
//  ld_addr      in   ADDR_W  address of the load currently in MEM
//  ld_hazard    out  1       load must stall
//  sb_empty     out  1       no queued or in-flight store (fence/mmio drain)
//  wr_valid     out  1       to master cpu_aw_valid
//  wr_ready     in   1       from master cpu_aw_ready (high only while master is idle)
//  wr_id        out  4       to cpu_id, constant ID
//  wr_addr      out  ADDR_W  to cpu_addr, head entry address
//  wr_data      out  DATA_W  to cpu_data, head data, lane-aligned
//  wr_len       out  8       to cpu_len, constant 0
//  wr_size      out  2       to cpu_size, head entry size
//  wr_resp      in   2       from cpu_w_resp
//  err          out  1       sticky: a write got a non-OKAY response
//  err_addr     out  ADDR_W  address of the first failing write
//  err_clr      in   1       clears err (err_addr kept)
// BEHAVIOUR
//  - Reset: rd/wr pointers=0, count=0, FSM=IDLE, wr_valid=0, err=0, err_addr=0; st_ready=1, sb_empty=1.
//  - Push when st_valid&&st_ready; st_ready = (count!=DEPTH). Does not look at same-cycle pop (no full bypass).
//  - Stored data = st_data << {st_addr[2:0],3'b0}, truncated to DATA_W. Lanes outside size are don't-care.
//  - Drain FSM:
//    - IDLE: count!=0 -> SEND.
//    - SEND: wr_valid=1. wr_valid&&wr_ready -> BUSY, and wr_valid drops the next cycle.
//    - BUSY: wr_valid=0; wait for wr_ready==1 (master back in idle, wr_resp now valid) -> pop head, go to IDLE.
//  - Head fields (wr_addr/data/size) stay stable from SEND until the pop; the FIFO is never written at rd_ptr.
//  - At pop: if wr_resp!=2'b00 and err==0, set err=1 and err_addr=head addr. A later error does not overwrite err_addr.
//  - Same cycle err_clr and a new error: the error wins.
//  - Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  - Minimum drain period: 1 (IDLE) + 1 (SEND) + master latency.
//  - sb_empty = (count==0) && FSM==IDLE.
//  - Reset asserted mid-transaction: all queued stores are discarded; the master is reset by the same reset_n.
// CONFIGURATION
//  YSYX_22041071_SB_HAZARD_EN defined:
//    - ld_hazard=1 iff any valid entry (including the in-flight head) has addr[ADDR_W-1:3]==ld_addr[ADDR_W-1:3].
//  Not defined:
//    - ld_hazard = ~sb_empty (conservative: every load waits for a full drain).
// STRUCTURE
//  - define.v: DEPTH-independent constants SB_IDLE/SB_SEND/SB_BUSY (2-bit) and AXI_RESP_OKAY.
//  - One sub-module ysyx_22041071_sb_fifo: storage, pointers, count, full/empty, per-entry valid vector
//    (the vector is used by the hazard compare).
//  - Drain FSM, error capture and hazard compare live in the top.
// TESTING
//  - Store 8B @0x8000_0010, data 0x1122334455667788:
//    -> wr_addr=0x...10, wr_size=3, wr_data unchanged; popped when wr_ready re-rises; sb_empty=1.
//  - Store 1B @0x8000_0003, data 0xAB -> wr_data=0x00000000AB000000, wr_size=0.
//  - Hold wr_ready=0 and push 4 stores -> st_ready=0 after the 4th; a 5th st_valid is held.
//    Release wr_ready -> 4 writes issued in order.
//  - Full FIFO, push and pop in the same cycle -> count stays 3 (not full) after pop-only; no entry lost or duplicated.
//  - wr_resp=2'b10 on the 2nd of 3 writes -> err=1, err_addr=2nd addr; the 3rd still drains; err_clr -> err=0.
//  - HAZARD_EN: queue a store @0x100, ld_addr=0x104 -> ld_hazard=1; ld_addr=0x108 -> 0.
//    Without the macro -> 1 until empty.

Source files
------------

// File: rtl/ysyx_22041071_store_buffer_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_store_buffer_pkg
//   Shared constants and types for the posted store buffer.
//   - sb_state_t     : drain FSM encoding (SB_IDLE / SB_SEND / SB_BUSY, 2 bits,
//                      independent of the FIFO depth)
//   - AXI_RESP_OKAY  : the only write response that does not raise err
//   - SB_SIZE_W      : width of the AXI size field (1B/2B/4B/8B)
//   - lane_shift()   : byte offset -> bit shift used to lane-align store data
// ----------------------------------------------------------------------------
package ysyx_22041071_store_buffer_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'b00,
        SB_SEND = 2'b01,
        SB_BUSY = 2'b10
    } sb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         SB_SIZE_W     = 2;

    // A store to byte offset N of a doubleword lands in byte lane N.
    function automatic logic [5:0] lane_shift(input logic [2:0] offset);
        return {offset, 3'b000};
    endfunction

endpackage

// File: rtl/ysyx_22041071_sb_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_sb_fifo
//   In-order storage for queued stores. Entries are written at wr_ptr and
//   read at rd_ptr; the head entry (rd_ptr) is never overwritten while it is
//   valid, so head_* stay stable until the entry is popped.
//   Ports:
//     clk, reset_n            clock, synchronous active-low reset
//     push, push_addr/data/size  enqueue one store (caller guarantees !full)
//     pop                     dequeue the head (caller guarantees !empty)
//     head_addr/data/size     oldest entry
//     full, empty             occupancy flags
//     entry_valid[DEPTH]      per-slot occupancy, for address compares
//     entry_addr[DEPTH]       per-slot address, for address compares
// ----------------------------------------------------------------------------
module ysyx_22041071_sb_fifo
    import ysyx_22041071_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             push,
    input  logic [ADDR_W-1:0]                push_addr,
    input  logic [DATA_W-1:0]                push_data,
    input  logic [SB_SIZE_W-1:0]             push_size,
    input  logic                             pop,
    output logic [ADDR_W-1:0]                head_addr,
    output logic [DATA_W-1:0]                head_data,
    output logic [SB_SIZE_W-1:0]             head_size,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]                 rd_ptr;
    logic [PTR_W-1:0]                 wr_ptr;
    logic [CNT_W-1:0]                 count;
    logic [DEPTH-1:0]                 valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0]     addr_mem;
    logic [DEPTH-1:0][DATA_W-1:0]     data_mem;
    logic [DEPTH-1:0][SB_SIZE_W-1:0]  size_mem;

    // Control state. Pointers are PTR_W wide, so DEPTH being a power of two
    // makes them wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase

            // Push and pop never target the same slot (pop needs a valid
            // head, push needs a free slot), so the order here is harmless.
            if (pop)  valid_q[rd_ptr] <= 1'b0;
            if (push) valid_q[wr_ptr] <= 1'b1;
        end
    end

    // Payload storage needs no reset: a slot is only read once valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
            size_mem[wr_ptr] <= push_size;
        end
    end

    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign head_size   = size_mem[rd_ptr];
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign entry_valid = valid_q;
    assign entry_addr  = addr_mem;

endmodule

// File: rtl/ysyx_22041071_store_buffer.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_store_buffer
//   Posted store buffer between the LSU and the AXI write-channel master.
//   Stores are queued in a DEPTH-entry FIFO and drained in order, one
//   single-beat write at a time. The head is popped only once the master
//   reports idle again (wr_ready re-rises), at which point wr_resp is valid.
//
//   Build option: YSYX_22041071_SB_HAZARD_EN
//     defined     : ld_hazard only when a queued store (in-flight head
//                   included) hits the same doubleword as ld_addr
//     not defined : ld_hazard = ~sb_empty (every load waits for a drain)
//
//   Ports:
//     clk, reset_n                 clock, synchronous active-low reset
//     st_valid/st_ready            LSU store handshake
//     st_addr/st_data/st_size      store address, LSB-justified data, size
//     ld_addr / ld_hazard          load address in MEM / load must stall
//     sb_empty                     nothing queued and nothing in flight
//     wr_valid/wr_ready            write request to / idle from the master
//     wr_id/wr_addr/wr_data/wr_len/wr_size  write command (head entry)
//     wr_resp                      write response, valid when wr_ready re-rises
//     err/err_addr/err_clr         sticky write error, first failing address
//
//   Handshakes: a store is taken on any cycle with st_valid && st_ready;
//   st_ready depends only on the current occupancy, never on a same-cycle
//   pop. A write is issued on the cycle wr_valid && wr_ready; wr_valid then
//   stays low until the head has been retired.
// ----------------------------------------------------------------------------
module ysyx_22041071_store_buffer
    import ysyx_22041071_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID     = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [ADDR_W-1:0]    st_addr,
    input  logic [DATA_W-1:0]    st_data,
    input  logic [1:0]           st_size,
    input  logic [ADDR_W-1:0]    ld_addr,
    output logic                 ld_hazard,
    output logic                 sb_empty,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [3:0]           wr_id,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [7:0]           wr_len,
    output logic [1:0]           wr_size,
    input  logic [1:0]           wr_resp,
    output logic                 err,
    output logic [ADDR_W-1:0]    err_addr,
    input  logic                 err_clr
);

    sb_state_t                   state;
    sb_state_t                   state_nxt;
    logic                        push;
    logic                        pop;
    logic                        issue;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [DATA_W-1:0]           lane_data;
    logic [ADDR_W-1:0]           head_addr;
    logic [DATA_W-1:0]           head_data;
    logic [SB_SIZE_W-1:0]        head_size;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;

    // ------------------------------------------------------------------
    // Store intake
    // ------------------------------------------------------------------
    assign st_ready  = !fifo_full;
    assign push      = st_valid && st_ready;
    assign lane_data = st_data << lane_shift(st_addr[2:0]);

    ysyx_22041071_sb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .push_addr   (st_addr),
        .push_data   (lane_data),
        .push_size   (st_size),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .head_size   (head_size),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // ------------------------------------------------------------------
    // Drain FSM
    //   IDLE -> SEND when anything is queued
    //   SEND -> BUSY on wr_valid && wr_ready (master accepted the write)
    //   BUSY -> IDLE when wr_ready returns: response is valid, pop head
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) state <= SB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pop       = 1'b0;
        unique case (state)
            SB_IDLE: begin
                if (!fifo_empty) state_nxt = SB_SEND;
            end
            SB_SEND: begin
                issue = 1'b1;
                if (wr_ready) state_nxt = SB_BUSY;
            end
            SB_BUSY: begin
                if (wr_ready) begin
                    pop       = 1'b1;
                    state_nxt = SB_IDLE;
                end
            end
            default: state_nxt = SB_IDLE;
        endcase
    end

    assign wr_valid = issue;
    assign wr_id    = 4'(ID);
    assign wr_len   = 8'd0;
    assign wr_addr  = head_addr;
    assign wr_data  = head_data;
    assign wr_size  = head_size;
    assign sb_empty = fifo_empty && (state == SB_IDLE);

    // ------------------------------------------------------------------
    // Sticky error capture. Only the first failure records its address;
    // a new failure in the same cycle as err_clr keeps err set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (pop && (wr_resp != AXI_RESP_OKAY)) begin
            err <= 1'b1;
            if (!err) err_addr <= head_addr;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load hazard
    // ------------------------------------------------------------------
`ifdef YSYX_22041071_SB_HAZARD_EN
    logic hazard_hit;
    logic unused_ld_offset;

    // Compare at doubleword granularity against every occupied slot,
    // the in-flight head included.
    always_comb begin
        hazard_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                (entry_addr[i][ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
                hazard_hit = 1'b1;
            end
        end
    end

    assign ld_hazard        = hazard_hit;
    assign unused_ld_offset = ^ld_addr[2:0];
`else
    logic unused_hazard_inputs;

    assign ld_hazard            = !sb_empty;
    assign unused_hazard_inputs = ^{ld_addr, entry_valid, entry_addr};
`endif

endmodule

// File: tb/tb_ysyx_22041071_store_buffer.sv
`timescale 1ns/1ps
module tb_ysyx_22041071_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                st_valid = 1'b0;
    logic                st_ready;
    logic [ADDR_W-1:0]   st_addr  = '0;
    logic [DATA_W-1:0]   st_data  = '0;
    logic [1:0]          st_size  = '0;
    logic [ADDR_W-1:0]   ld_addr  = '0;
    logic                ld_hazard;
    logic                sb_empty;
    logic                wr_valid;
    logic                wr_ready = 1'b0;
    logic [3:0]          wr_id;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [7:0]          wr_len;
    logic [1:0]          wr_size;
    logic [1:0]          wr_resp  = 2'b00;
    logic                err;
    logic [ADDR_W-1:0]   err_addr;
    logic                err_clr  = 1'b0;

    ysyx_22041071_store_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard), .sb_empty(sb_empty),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len),
        .wr_size(wr_size), .wr_resp(wr_resp),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } st_t;

    // Reference model: an in-order queue of stores (the in-flight head stays
    // at the front until retired), a sticky error flag and its address.
    st_t         m_q[$];
    logic        in_flight  = 1'b0;
    logic        m_err      = 1'b0;
    logic [63:0] m_err_addr = '0;
    logic        m_accept   = 1'b0;
    logic [63:0] issued_q[$];

    function automatic logic [63:0] lane_mask(input logic [63:0] a, input logic [1:0] sz);
        logic [63:0] m;
        int nb;
        int off;
        m   = '0;
        nb  = 1 << sz;
        off = int'(a[2:0]);
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + nb) m[b*8 +: 8] = 8'hff;
        return m;
    endfunction

    function automatic logic exp_hazard();
`ifdef YSYX_22041071_SB_HAZARD_EN
        foreach (m_q[i])
            if ((m_q[i].addr >> 3) == (ld_addr >> 3)) return 1'b1;
        return 1'b0;
`else
        return m_q.size() != 0;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Compare process: outputs are checked on the falling edge, then the
    // model is advanced to what the next rising edge will produce.
    // ------------------------------------------------------------------
    int   idle_wait  = 0;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    always @(negedge clk) begin
        logic        hs;
        logic        do_pop;
        logic        do_push;
        logic [63:0] mask;
        logic [63:0] exp_d;
        st_t         e;

        check("st_ready",  st_ready,  m_q.size() != DEPTH);
        check("sb_empty",  sb_empty,  m_q.size() == 0);
        check("ld_hazard", ld_hazard, exp_hazard());
        check("err",       err,       m_err);
        check("err_addr",  err_addr,  m_err_addr);
        if (in_flight || m_q.size() == 0) check("wr_valid_idle", wr_valid, 0);
        if (prev_valid && !prev_hs)        check("wr_valid_hold", wr_valid, 1);
        if (wr_valid && m_q.size() > 0) begin
            mask  = lane_mask(m_q[0].addr, m_q[0].size);
            exp_d = m_q[0].data << (8 * int'(m_q[0].addr[2:0]));
            check("wr_addr", wr_addr, m_q[0].addr);
            check("wr_size", wr_size, m_q[0].size);
            check("wr_data", wr_data & mask, exp_d & mask);
            check("wr_id",   wr_id, 0);
            check("wr_len",  wr_len, 0);
        end
        if (m_q.size() > 0 && !in_flight && !wr_valid) idle_wait++;
        else idle_wait = 0;
        check("issue_delay", idle_wait > 1, 0);

        if (!reset_n) begin
            m_q.delete();
            in_flight  = 1'b0;
            m_err      = 1'b0;
            m_err_addr = '0;
            m_accept   = 1'b0;
            idle_wait  = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            hs       = wr_valid && wr_ready;
            do_pop   = in_flight && wr_ready;
            do_push  = st_valid && (m_q.size() != DEPTH);
            m_accept = hs;
            if (hs) issued_q.push_back(wr_addr);
            if (do_pop && m_q.size() > 0) begin
                if (wr_resp != 2'b00) begin
                    if (!m_err) m_err_addr = m_q[0].addr;
                    m_err = 1'b1;
                end else if (err_clr) begin
                    m_err = 1'b0;
                end
                void'(m_q.pop_front());
                in_flight = 1'b0;
            end else begin
                if (err_clr) m_err = 1'b0;
                if (hs) in_flight = 1'b1;
            end
            if (do_push) begin
                e.addr = st_addr;
                e.data = st_data;
                e.size = st_size;
                m_q.push_back(e);
            end
            prev_valid = wr_valid;
            prev_hs    = hs;
        end
    end

    // ------------------------------------------------------------------
    // AXI write master model: idle -> ready; accepted write -> busy for
    // 1..3 cycles, then idle again with the response on wr_resp.
    // ------------------------------------------------------------------
    logic       busy        = 1'b0;
    int         lat         = 0;
    int         n_wr        = 0;
    int         err_at      = -1;
    logic       rand_err    = 1'b0;
    logic       hold_ready  = 1'b0;
    logic [1:0] resp_next   = 2'b00;

    always @(posedge clk) begin
        logic rst_edge;
        logic acc;
        rst_edge = !reset_n;
        acc      = m_accept;
        #2;
        if (rst_edge) begin
            busy    = 1'b0;
            lat     = 0;
            wr_resp = 2'b00;
        end else if (acc) begin
            busy = 1'b1;
            lat  = $urandom_range(1, 3);
            n_wr++;
            resp_next = ((n_wr == err_at) || (rand_err && $urandom_range(0, 5) == 0)) ? 2'b10 : 2'b00;
            wr_resp   = 2'b11;
        end else if (busy) begin
            lat--;
            if (lat == 0) begin
                busy    = 1'b0;
                wr_resp = resp_next;
            end
        end
        wr_ready = !busy && !hold_ready;
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        bit ok;
        int budget;
        ok       = 0;
        budget   = 200;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (st_ready) ok = 1;
            else budget--;
            tick();
        end
        st_valid = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic wait_empty(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = sb_empty;
        end
        tick();
        check("drain_done", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit rose;

        // Reset
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_st_ready", st_ready, 1);
        check("rst_sb_empty", sb_empty, 1);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_err",      err, 0);
        check("rst_err_addr", err_addr, 0);
        tick();

        // 8-byte aligned store: two-cycle issue latency, data untouched
        push_store(64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3);
        @(negedge clk);
        check("t1_lat_idle", wr_valid, 0);
        @(negedge clk);
        check("t1_lat_send", wr_valid, 1);
        check("t1_addr", wr_addr, 64'h8000_0010);
        check("t1_size", wr_size, 3);
        check("t1_data", wr_data, 64'h1122_3344_5566_7788);
        wait_empty(50);

        // 1-byte store at offset 3 lands in lane 3
        push_store(64'h8000_0003, 64'h0000_0000_0000_00AB, 2'd0);
        @(negedge clk);
        @(negedge clk);
        check("t2_valid", wr_valid, 1);
        check("t2_data", wr_data, 64'h0000_0000_AB00_0000);
        check("t2_size", wr_size, 0);
        wait_empty(50);

        // Fill with the master held off, a 5th store must wait
        issued_q.delete();
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++)
            push_store(64'h8000_0100 + 64'(8 * i), 64'(32'hC0DE_0000 + i), 2'd3);
        @(negedge clk);
        check("full_st_ready", st_ready, 0);
        tick();
        st_valid = 1'b1;
        st_addr  = 64'h8000_0200;
        st_data  = 64'hFEED;
        st_size  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_hold", st_ready, 0);
            tick();
        end
        hold_ready = 1'b0;
        rose = 0;
        for (int i = 0; i < 40 && !rose; i++) begin
            @(negedge clk);
            rose = st_ready;
            tick();
        end
        check("pop_frees_slot", rose, 1);
        st_valid = 1'b0;
        wait_empty(100);
        check("order_cnt", issued_q.size(), 5);
        for (int i = 0; i < 4; i++)
            if (i < issued_q.size()) check("order_addr", issued_q[i], 64'h8000_0100 + 64'(8 * i));
        if (issued_q.size() > 4) check("order_addr5", issued_q[4], 64'h8000_0200);

        // Error on the 2nd of 3 writes
        issued_q.delete();
        err_at = n_wr + 2;
        push_store(64'h8000_1000, 64'h1, 2'd3);
        push_store(64'h8000_2008, 64'h2, 2'd3);
        push_store(64'h8000_3010, 64'h3, 2'd3);
        wait_empty(100);
        err_at = -1;
        @(negedge clk);
        check("e_err", err, 1);
        check("e_err_addr", err_addr, 64'h8000_2008);
        check("e_drained", issued_q.size(), 3);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("e_clr", err, 0);
        check("e_addr_kept", err_addr, 64'h8000_2008);
        tick();

        // Load hazard against a queued store
        hold_ready = 1'b1;
        tick(); tick();
        push_store(64'h0000_0100, 64'h55, 2'd3);
        ld_addr = 64'h0000_0104;
        @(negedge clk);
        check("hz_same_dw", ld_hazard, 1);
        tick();
        ld_addr = 64'h0000_0108;
        @(negedge clk);
`ifdef YSYX_22041071_SB_HAZARD_EN
        check("hz_next_dw", ld_hazard, 0);
`else
        check("hz_next_dw", ld_hazard, 1);
`endif
        tick();
        hold_ready = 1'b0;
        wait_empty(50);
        @(negedge clk);
        check("hz_drained", ld_hazard, 0);
        tick();

        // Reset with a write in flight and stores queued
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++)
            push_store(64'h8000_4000 + 64'(8 * i), 64'(i), 2'd3);
        hold_ready = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("mrst_empty", sb_empty, 1);
        check("mrst_ready", st_ready, 1);
        check("mrst_valid", wr_valid, 0);
        tick();

        // Randomized traffic
        rand_err = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 64'h8000_0000 + 64'($urandom_range(0, 63));
            st_data  = {$urandom, $urandom};
            st_size  = 2'($urandom_range(0, 3));
            ld_addr  = 64'h8000_0000 + 64'($urandom_range(0, 63));
            err_clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) hold_ready = !hold_ready;
            reset_n  = (c != 700);
            tick();
        end
        st_valid   = 1'b0;
        err_clr    = 1'b0;
        hold_ready = 1'b0;
        reset_n    = 1'b1;
        wait_empty(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
